im_axi_rd_bridge: RTL
=====================

Name: im_axi_rd_bridge

Overview:
- Downstream neighbour of the L1 instruction-cache controller.
- Converts the controller's refill word requests (im_enable, im_address) into single-beat AXI4-Lite-style read transactions to instruction memory.
- Returns each word with a one-cycle im_ready pulse; the controller advances its refill word counter on that pulse.
- One outstanding transaction at most; no bursts.

Parameters:
ADDR_W, 32, request/bus address width
DATA_W, 32, instruction word width
TIMEOUT_CYC, 255, bus-phase cycle limit before error return (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
im_enable  in  1  word request from cache controller, held high until im_ready
im_address  in  ADDR_W  requested word address
im_ready  out  1  one-cycle pulse: im_rdata/im_err valid
im_rdata  out  DATA_W  returned instruction word, held until next capture
im_err  out  1  error flag qualified by im_ready
busy  out  1  high whenever state is not IDLE
araddr  out  ADDR_W  read address, word-aligned
arvalid  out  1  read address valid
arready  in  1  read address accepted
rdata  in  DATA_W  read data
rresp  in  2  read response
rvalid  in  1  read data valid
rready  out  1  read data ready

Behaviour:
- States: IDLE, ADDR, DATA, DONE, plus DRAIN (only with the optional feature). All outputs are registered or decoded from state.
- Reset (rst=0, asynchronous):
  - state goes to IDLE.
  - arvalid, rready, im_ready, im_err and busy go to 0.
  - araddr and im_rdata go to 0.
  - A transaction in flight is abandoned; the bus shares the same reset.
- IDLE:
  - arvalid=0, rready=0.
  - If im_enable=1: latch araddr = {im_address[ADDR_W-1:2], 2'b00} and go to ADDR.
- ADDR:
  - arvalid=1, araddr stable.
  - arvalid never drops before arready. On arready=1, go to DATA.
- DATA:
  - rready=1.
  - On rvalid=1: capture im_rdata=rdata and im_err=rresp[1] (SLVERR or DECERR), then go to DONE.
- DONE:
  - im_ready = im_enable, a single cycle; then go to IDLE.
  - If the requester dropped im_enable mid-transaction, the bus transaction still completes, im_rdata is still updated, and no pulse is issued.
- Latency:
  - With arready and rvalid both high on first opportunity: enable sampled at cycle 0, arvalid at cycle 1, rready at cycle 2, im_ready at cycle 3.
  - Back-to-back requests take 4 cycles per word minimum. The next ADDR is no earlier than 2 cycles after an im_ready pulse.
- Same-address re-request: if im_enable stays high after the pulse (controller stalled), the bridge issues a fresh read of the current im_address. This is allowed and harmless.
- Simultaneous events:
  - arready in the same cycle arvalid first rises is accepted.
  - rvalid arriving while still in ADDR is ignored until DATA; rready is 0 there.
- im_rdata is not cleared between transactions.

Optional Feature:
- Macro: IM_AXI_RD_BRIDGE_TIMEOUT_EN.
- With the macro: a watchdog counter of width $clog2(TIMEOUT_CYC+1).
  - Clears on entry to ADDR and counts every cycle in ADDR or DATA.
  - On reaching TIMEOUT_CYC: go to DONE with im_rdata=0 and im_err=1.
  - Then go to DRAIN instead of IDLE. DRAIN keeps arvalid high until arready if the address was not yet accepted, then holds rready=1 until rvalid, discarding data, then goes to IDLE.
  - busy stays high in DRAIN.
- Without the macro: no counter and no DRAIN state; the bridge waits indefinitely.

Decomposition:
- Package im_axi_rd_pkg holds:
  - state enum typedef (IDLE, ADDR, DATA, DONE, DRAIN);
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- Sub-module im_axi_rd_wdt (watchdog counter, clear/enable in, expire out) is natural and is instantiated only under IM_AXI_RD_BRIDGE_TIMEOUT_EN.

Test Plan:
- Reset: hold rst=0 mid-DATA with rvalid low, then release -> state IDLE, arvalid=0, rready=0, im_ready=0, busy=0 the cycle rst goes low.
- Zero-wait read: im_enable=1, im_address=0x0000_1004; arready and rvalid tied high, rdata=0xDEAD_BEEF, rresp=00 -> araddr=0x0000_1004, im_ready pulses at cycle 3 with im_rdata=0xDEAD_BEEF, im_err=0.
- 4-word refill: controller model steps addresses 0x100, 0x104, 0x108, 0x10C on each im_ready; arready delayed 2 cycles, rvalid delayed 3 -> four pulses with matching data, arvalid never drops early, no extra transaction.
- Unaligned and error: im_address=0x0000_2007, rresp=2'b10 -> araddr=0x0000_2004, im_ready with im_err=1.
- Request withdrawn: drop im_enable while in DATA; rvalid later with rdata=0x1234_5678 -> no im_ready pulse, im_rdata=0x1234_5678, return to IDLE.
- Timeout (macro on, TIMEOUT_CYC=8): arready never asserted -> im_ready with im_err=1, im_rdata=0 after 8 bus-phase cycles. Then arready=1, rvalid=1 with rdata=0xAAAA_AAAA -> data discarded, busy falls, IDLE.

Source files
------------

// File: rtl/im_axi_rd_pkg.sv
// Shared types and AXI read-response codes for the instruction-memory read bridge.
package im_axi_rd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/im_axi_rd_wdt.sv
// Bus-phase watchdog: cleared when a transaction starts, counts while enabled,
// flags expiry on the LIMIT-th counted cycle.
module im_axi_rd_wdt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(LIMIT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/im_axi_rd_bridge.sv
// Turns I-cache refill word requests into single-beat AXI4-Lite reads.
// Optional bus watchdog with drain recovery: define IM_AXI_RD_BRIDGE_TIMEOUT_EN.
module im_axi_rd_bridge
  import im_axi_rd_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_enable,
  input  logic [ADDR_W-1:0] im_address,
  output logic              im_ready,
  output logic [DATA_W-1:0] im_rdata,
  output logic              im_err,
  output logic              busy,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  state_t state;

  // Word alignment drops the byte offset on purpose.
  logic unused_bits;
  assign unused_bits = ^im_address[1:0];

`ifdef IM_AXI_RD_BRIDGE_TIMEOUT_EN
  logic tmo_hit;
  logic tmo_flag;

  im_axi_rd_wdt #(.LIMIT(TIMEOUT_CYC)) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state == IDLE) && im_enable),
    .en     ((state == ADDR) || (state == DATA)),
    .expire (tmo_hit)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      im_ready <= 1'b0;
      im_err   <= 1'b0;
      araddr   <= '0;
      im_rdata <= '0;
`ifdef IM_AXI_RD_BRIDGE_TIMEOUT_EN
      tmo_flag <= 1'b0;
`endif
    end else begin
      im_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (im_enable) begin
            araddr  <= {im_address[ADDR_W-1:2], 2'b00};
            arvalid <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= DATA;
          end
`ifdef IM_AXI_RD_BRIDGE_TIMEOUT_EN
          else if (tmo_hit) begin
            // arvalid stays up: the address must still be handed over in DRAIN.
            im_rdata <= '0;
            im_err   <= 1'b1;
            im_ready <= im_enable;
            tmo_flag <= 1'b1;
            state    <= DONE;
          end
`endif
        end
        DATA: begin
          if (rvalid) begin
            rready   <= 1'b0;
            im_rdata <= rdata;
            im_err   <= resp_is_err(rresp);
            im_ready <= im_enable;
            state    <= DONE;
          end
`ifdef IM_AXI_RD_BRIDGE_TIMEOUT_EN
          else if (tmo_hit) begin
            im_rdata <= '0;
            im_err   <= 1'b1;
            im_ready <= im_enable;
            tmo_flag <= 1'b1;
            state    <= DONE;
          end
`endif
        end
        DONE: begin
`ifdef IM_AXI_RD_BRIDGE_TIMEOUT_EN
          if (tmo_flag) begin
            // Late bus handshakes may land here already; carry them into DRAIN.
            if (arvalid && arready) begin
              arvalid <= 1'b0;
              rready  <= 1'b1;
            end else if (rready && rvalid) begin
              rready <= 1'b0;
            end
            state <= DRAIN;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
`ifdef IM_AXI_RD_BRIDGE_TIMEOUT_EN
        DRAIN: begin
          if (arvalid) begin
            if (arready) begin
              arvalid <= 1'b0;
              rready  <= 1'b1;
            end
          end else if (rready) begin
            if (rvalid) begin
              rready   <= 1'b0;
              tmo_flag <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            tmo_flag <= 1'b0;
            state    <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
